// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address-width function, default sizes and an elaboration-time
// parameter check reusable by single- and dual-clock FIFO variants.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 64;

  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

`define FIFO_PARAM_CHECK(depth_p, ae_p, af_p) \
  if (!fifo_pkg::is_pow2(depth_p) || (depth_p) < 4 || !((ae_p) < (af_p)) || (af_p) > (depth_p)) begin : g_bad_params \
    $error("fifo: DEPTH must be a power of 2 >= 4 and AE_THRESH < AF_THRESH <= DEPTH"); \
  end

`endif

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port array: one write port, one synchronous read port; read data holds
// when no read is issued. Read-before-write when both ports hit the same slot.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter  int DATA_W = FIFO_DATA_W_DEF,
  parameter  int DEPTH  = FIFO_DEPTH_DEF,
  localparam int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with watermarks, sticky overflow/underflow and synchronous flush; read latency 1.
// Writes are refused only when full with no simultaneous read; reads are refused when empty.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W    = FIFO_DATA_W_DEF,
  parameter  int DEPTH     = FIFO_DEPTH_DEF,
  parameter  int AF_THRESH = 56,
  parameter  int AE_THRESH = 8,
  localparam int AW        = clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  `FIFO_PARAM_CHECK(DEPTH, AE_THRESH, AF_THRESH)

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              dout_zero;
  logic [DATA_W-1:0] ram_rdata;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign almost_full  = (count >= CW'(AF_THRESH));

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~clr),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc & ~clr),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // The array register has no reset; dout_zero masks it to 0 until the first read after rst/clr.
  assign dout = dout_zero ? '0 : ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      dout_zero  <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      dout_zero  <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + AW'(1);
        dout_zero <= 1'b0;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      dout_valid <= rd_acc;
      if (wr_en & ~wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en & empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomized and directed checks of sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int AF     = 56;
  localparam int AE     = 8;
  localparam int CW     = 7;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  sync_fifo_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_dv;
  logic              m_ovf;
  logic              m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic c, input logic [DATA_W-1:0] d);
    int  n;
    bit  rd_ok;
    bit  wr_ok;
    if (c) begin
      model_reset();
    end else begin
      n     = q.size();
      rd_ok = r && (n != 0);
      wr_ok = w && ((n != DEPTH) || r);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && (n == 0)) m_udf = 1'b1;
      m_dv = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("dout", 32'(dout), 32'(m_dout));
  endtask

  // Drives one cycle's inputs, lets the edge happen, then compares 1 time unit later.
  task automatic cycle(input logic w, input logic r, input logic c, input logic [DATA_W-1:0] d);
    wr_en = w;
    rd_en = r;
    clr   = c;
    din   = d;
    @(posedge clk);
    model_step(w, r, c, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    din   = '0;
    rst   = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    do_reset();

    // reset then idle
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // fill to full, one refused write, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    chk("full_after_64", 32'(full), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("ovf_after_65", 32'(overflow), 32'd1);
    chk("count_after_65", 32'(count), 32'd64);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // read on empty
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("udf_on_empty", 32'(underflow), 32'd1);
    chk("dout_hold", 32'(dout), 32'h3F);

    // full with simultaneous read and write across pointer wrap
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
    chk("rw_full_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // watermarks, then flush with a concurrent write
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 57; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 49; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ae_at_8", 32'(almost_empty), 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 8'h55);
    chk("clr_count", 32'(count), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // async reset mid-stream with 30 entries
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 31; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // randomized traffic with shifting write/read bias
    for (int n = 0; n < 4000; n++) begin
      int  phase;
      int  pw;
      int  pr;
      logic w;
      logic r;
      logic c;
      phase = (n / 400) % 3;
      pw = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      pr = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
      w = ($urandom_range(0, 99) < pw);
      r = ($urandom_range(0, 99) < pr);
      c = ($urandom_range(0, 299) == 0);
      cycle(w, r, c, 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
